quad_step_decoder: RTL

- Quadrature step decoder that drives the up/down/load command inputs of the 5-bit saturating up/down counter.
- Synchronises asynchronous A/B encoder phases and an index (home) input.
- Decodes Gray-code phase transitions into single-cycle up or down pulses, and index rising edges into a single-cycle load pulse with a home value.
- Flags illegal double-phase transitions in a sticky error bit.

---
 rtl/quad_step_decoder_if.sv | 29 ++
 rtl/quad_step_decoder.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/quad_step_decoder_if.sv
// Quadrature decoder bundle: encoder/index inputs, control strobes and counter commands.
// Latency: none, wires only.
// Backpressure: none; commands are single-cycle pulses the counter must accept.
interface quad_step_decoder_if #(
  parameter int WIDTH = 5
);
  logic             a_in;
  logic             b_in;
  logic             idx_in;
  logic             enable;
  logic             err_clr;
  logic             up;
  logic             down;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             err;

  // Decoder side: consumes encoder/control inputs, produces counter commands.
  modport slave (
    input  a_in, b_in, idx_in, enable, err_clr,
    output up, down, load, load_val, err
  );

  // Stimulus side: drives encoder/control inputs, observes counter commands.
  modport master (
    output a_in, b_in, idx_in, enable, err_clr,
    input  up, down, load, load_val, err
  );
endinterface

// File: rtl/quad_step_decoder.sv
// Quadrature step decoder: sync A/B/idx, decode Gray steps to up/down, index edge to load.
// Latency: input change to registered pulse in 3 clk edges (+FILTER_LEN when QDEC_FILTER_EN).
// Backpressure: none; enable=0 discards steps while phase/index history keeps tracking.
module quad_step_decoder #(
  parameter int               WIDTH      = 5,
  parameter logic [WIDTH-1:0] HOME_VALUE = 5'b10000,
  parameter int               FILTER_LEN = 3
) (
  input  logic clk,
  input  logic rst_n,
  quad_step_decoder_if.slave qd
);

  typedef enum logic [1:0] {
    S_WAIT  = 2'd0,
    S_PRIME = 2'd1,
    S_TRACK = 2'd2
  } state_t;

  // WAIT covers the synchroniser flush plus, when present, the filter settle time.
`ifdef QDEC_FILTER_EN
  localparam int WAIT_CYC = 2 + FILTER_LEN;
`else
  localparam int WAIT_CYC = 2;
`endif

  if (FILTER_LEN < 2 || FILTER_LEN > 15) begin : g_bad_filter_len
    $error("quad_step_decoder: FILTER_LEN must be in 2..15");
  end

  // Bit order in the 3-bit vectors below: {A, B, idx}.
  logic [2:0] r_sync1;
  logic [2:0] r_sync2;
  logic [2:0] w_filt;

  logic [1:0] r_prev_ab;
  logic       r_prev_idx;
  logic [1:0] w_cur_ab;
  logic       w_cur_idx;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [4:0] r_wait_cnt;

  logic       w_up;
  logic       w_down;
  logic       w_load;
  logic       w_err_set;
  logic [1:0] w_step;

  logic             r_up;
  logic             r_down;
  logic             r_load;
  logic [WIDTH-1:0] r_load_val;
  logic             r_err;

  // Position of a phase pair along the forward sequence 00->10->11->01.
  function automatic logic [1:0] gray_pos(input logic [1:0] ab);
    case (ab)
      2'b00:   gray_pos = 2'd0;
      2'b10:   gray_pos = 2'd1;
      2'b11:   gray_pos = 2'd2;
      default: gray_pos = 2'd3;
    endcase
  endfunction

  // Two-flop synchronisers for the asynchronous encoder and index inputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= 3'b000;
      r_sync2 <= 3'b000;
    end else begin
      r_sync1 <= {qd.a_in, qd.b_in, qd.idx_in};
      r_sync2 <= r_sync1;
    end
  end

`ifdef QDEC_FILTER_EN
  logic [2:0] r_filt;
  logic [3:0] r_fcnt [3];

  // Glitch filter: a new level is adopted only after FILTER_LEN consecutive cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_filt <= 3'b000;
      for (int i = 0; i < 3; i++) r_fcnt[i] <= 4'd0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (r_sync2[i] == r_filt[i]) begin
          r_fcnt[i] <= 4'd0;
        end else if (r_fcnt[i] == 4'(FILTER_LEN - 1)) begin
          r_filt[i] <= r_sync2[i];
          r_fcnt[i] <= 4'd0;
        end else begin
          r_fcnt[i] <= r_fcnt[i] + 4'd1;
        end
      end
    end
  end

  assign w_filt = r_filt;
`else
  assign w_filt = r_sync2;
`endif

  assign w_cur_ab  = w_filt[2:1];
  assign w_cur_idx = w_filt[0];
  assign w_step    = gray_pos(w_cur_ab) - gray_pos(r_prev_ab);

  // Phase/index history follows the decode inputs every cycle, enabled or not.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prev_ab  <= 2'b00;
      r_prev_idx <= 1'b0;
    end else begin
      r_prev_ab  <= w_cur_ab;
      r_prev_idx <= w_cur_idx;
    end
  end

  // FSM state register with the WAIT dwell counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_WAIT;
      r_wait_cnt <= 5'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= (r_state == S_WAIT) ? r_wait_cnt + 5'd1 : 5'd0;
    end
  end

  // FSM next state: flush in WAIT, one PRIME cycle to seed history, then TRACK forever.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_WAIT:  if (r_wait_cnt == 5'(WAIT_CYC - 1)) w_state_nxt = S_PRIME;
      S_PRIME: w_state_nxt = S_TRACK;
      S_TRACK: w_state_nxt = S_TRACK;
      default: w_state_nxt = S_WAIT;
    endcase
  end

  // FSM outputs: decode only in TRACK; index load overrides a coincident step.
  always_comb begin
    w_up      = 1'b0;
    w_down    = 1'b0;
    w_load    = 1'b0;
    w_err_set = 1'b0;
    if (r_state == S_TRACK) begin
      w_err_set = (w_step == 2'd2);
      if (qd.enable) begin
        if (w_cur_idx && !r_prev_idx) begin
          w_load = 1'b1;
        end else begin
          w_up   = (w_step == 2'd1);
          w_down = (w_step == 2'd3);
        end
      end
    end
  end

  // Registered command outputs and the sticky error flag (set beats clear).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_up       <= 1'b0;
      r_down     <= 1'b0;
      r_load     <= 1'b0;
      r_load_val <= '0;
      r_err      <= 1'b0;
    end else begin
      r_up       <= w_up;
      r_down     <= w_down;
      r_load     <= w_load;
      r_load_val <= w_load ? HOME_VALUE : '0;
      if (w_err_set) begin
        r_err <= 1'b1;
      end else if (qd.err_clr) begin
        r_err <= 1'b0;
      end
    end
  end

  assign qd.up       = r_up;
  assign qd.down     = r_down;
  assign qd.load     = r_load;
  assign qd.load_val = r_load_val;
  assign qd.err      = r_err;

endmodule
